// File: rtl/pad_serial_reader.sv
// pad_serial_reader
//   Console-side master for the NES/SNES controller serial protocol. Drives the
//   pad latch and shift clock, samples the pad's serial data line and presents
//   the decoded button state as a registered parallel word.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   poll_en      in   1 = start a frame every POLL_CYCLES clocks
//   pad_data     in   serial data from the pad, active-low, asynchronous
//   pad_latch    out  latch strobe to the pad, active-high
//   pad_clock    out  shift clock to the pad, idles high
//   buttons      out  bit k = 1 when serial bit k read as pressed
//   frame_valid  out  one-cycle pulse when buttons has just been updated
//   frame_err    out  one-cycle pulse on a rejected frame
//   busy         out  high from LATCH entry through DONE
//
// Build option
//   PAD_FRAME_CHECK_EN : with NUM_BITS == 16, a frame whose serial bits 12..15
//   do not all read released is rejected (buttons kept, frame_err pulsed).
//   Undefined: every frame is accepted and frame_err stays 0.

module pad_serial_reader #(
    parameter int NUM_BITS     = 16,
    parameter int LATCH_CYCLES = 144,
    parameter int HALF_CYCLES  = 72,
    parameter int POLL_CYCLES  = 200000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                poll_en,
    input  logic                pad_data,
    output logic                pad_latch,
    output logic                pad_clock,
    output logic [NUM_BITS-1:0] buttons,
    output logic                frame_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int TMR_W     = $clog2(PHASE_MAX);
    localparam int POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int IDX_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [TMR_W-1:0]  LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);
    localparam logic [TMR_W-1:0]  HALF_LOAD  = TMR_W'(HALF_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_ONE   = POLL_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_GAP   = 3'd2,
        ST_LOW   = 3'd3,
        ST_HIGH  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

`ifdef PAD_FRAME_CHECK_EN
    localparam int EXT_W = (NUM_BITS > 16) ? NUM_BITS : 16;

    // A 16-bit pad reports its four trailing bits as released (raw 1); anything
    // else means no pad, or an 8-bit pad on a 16-bit port.
    function automatic logic frame_ok_f(input logic [NUM_BITS-1:0] raw);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(raw);
        if (NUM_BITS == 16) begin
            frame_ok_f = &ext[15:12];
        end else begin
            frame_ok_f = 1'b1;
        end
    endfunction
`endif

    state_t              state_r, state_nxt_s;
    logic [TMR_W-1:0]    tmr_r, tmr_nxt_s;
    logic [IDX_W-1:0]    idx_r, idx_nxt_s;
    logic [POLL_W-1:0]   poll_cnt_r;
    logic                first_r;
    logic                sync1_r, sync2_r;
    logic [NUM_BITS-1:0] shift_r;
    logic                sample_s;
    logic                launch_s;
    logic                start_due_s;
    logic                tmr_zero_s;
    logic                frame_ok_s;

    logic                pad_latch_r, pad_clock_r, busy_r;
    logic                frame_valid_r, frame_err_r;
    logic [NUM_BITS-1:0] buttons_r;

    assign pad_latch   = pad_latch_r;
    assign pad_clock   = pad_clock_r;
    assign busy        = busy_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign buttons     = buttons_r;

    assign tmr_zero_s  = (tmr_r == {TMR_W{1'b0}});
    // A frame is due on the first enabled cycle after reset, or once a full
    // poll period has elapsed.
    assign start_due_s = poll_en && (first_r || (poll_cnt_r == POLL_LAST));

`ifdef PAD_FRAME_CHECK_EN
    assign frame_ok_s = frame_ok_f(shift_r);
`else
    assign frame_ok_s = 1'b1;
`endif

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= pad_data;
            sync2_r <= sync1_r;
        end
    end

    // Poll period counter; keeps running through a frame and saturates so a
    // period shorter than a frame launches the next frame straight from DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt_r <= {POLL_W{1'b0}};
            first_r    <= 1'b1;
        end else if (launch_s) begin
            poll_cnt_r <= {POLL_W{1'b0}};
            first_r    <= 1'b0;
        end else if (poll_en && (poll_cnt_r != POLL_LAST)) begin
            poll_cnt_r <= poll_cnt_r + POLL_ONE;
            first_r    <= first_r;
        end else begin
            poll_cnt_r <= poll_cnt_r;
            first_r    <= first_r;
        end
    end

    // Next-state logic: one shared down-counter times every phase.
    always_comb begin
        state_nxt_s = state_r;
        tmr_nxt_s   = tmr_r;
        idx_nxt_s   = idx_r;
        sample_s    = 1'b0;
        launch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_due_s) begin
                    state_nxt_s = ST_LATCH;
                    tmr_nxt_s   = LATCH_LOAD;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (tmr_zero_s) begin
                    state_nxt_s = ST_GAP;
                    tmr_nxt_s   = HALF_LOAD;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    tmr_nxt_s   = tmr_r - TMR_ONE;
                end
            end
            ST_GAP: begin
                if (tmr_zero_s) begin
                    state_nxt_s = ST_LOW;
                    tmr_nxt_s   = HALF_LOAD;
                    sample_s    = 1'b1;
                end else begin
                    tmr_nxt_s   = tmr_r - TMR_ONE;
                end
            end
            ST_LOW: begin
                if (tmr_zero_s) begin
                    state_nxt_s = ST_HIGH;
                    tmr_nxt_s   = HALF_LOAD;
                end else begin
                    tmr_nxt_s   = tmr_r - TMR_ONE;
                end
            end
            ST_HIGH: begin
                if (tmr_zero_s) begin
                    if (idx_r < IDX_LAST) begin
                        state_nxt_s = ST_LOW;
                        tmr_nxt_s   = HALF_LOAD;
                        idx_nxt_s   = idx_r + IDX_ONE;
                        sample_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    tmr_nxt_s   = tmr_r - TMR_ONE;
                end
            end
            ST_DONE: begin
                if (start_due_s) begin
                    state_nxt_s = ST_LATCH;
                    tmr_nxt_s   = LATCH_LOAD;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tmr_nxt_s   = {TMR_W{1'b0}};
                idx_nxt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, phase timer and bit index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            tmr_r   <= {TMR_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            tmr_r   <= tmr_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Sample shift register: each sample enters at the top, so after the last
    // sample serial bit k sits at position k.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r <= {NUM_BITS{1'b1}};
        end else if (sample_s) begin
            shift_r <= {sync2_r, shift_r[NUM_BITS-1:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Pin outputs follow the state being entered so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pad_latch_r <= 1'b0;
            pad_clock_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            pad_latch_r <= (state_nxt_s == ST_LATCH);
            pad_clock_r <= (state_nxt_s != ST_LOW);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Frame result: the whole button word is replaced at once, inverted to
    // active-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buttons_r     <= {NUM_BITS{1'b0}};
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else if (state_r == ST_DONE) begin
            buttons_r     <= frame_ok_s ? ~shift_r : buttons_r;
            frame_valid_r <= frame_ok_s;
`ifdef PAD_FRAME_CHECK_EN
            frame_err_r   <= ~frame_ok_s;
`else
            frame_err_r   <= 1'b0;
`endif
        end else begin
            buttons_r     <= buttons_r;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pad_serial_reader.sv
// Bench for pad_serial_reader: an SNES-width instance (poll period 200) and an
// NES-width instance (poll period 50, shorter than a frame), each wired to a
// behavioural controller model that latches a button pattern and shifts one
// bit per pad_clock rising edge.

module tb_pad_serial_reader;

    localparam int S_BITS  = 16;
    localparam int N_BITS  = 8;
    localparam int LAT     = 8;
    localparam int HALF    = 4;
    localparam int S_POLL  = 200;
    localparam int N_POLL  = 50;
    localparam int S_FRAME = LAT + (2 * S_BITS + 1) * HALF + 1;
    localparam int N_FRAME = LAT + (2 * N_BITS + 1) * HALF + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic s_poll_en = 1'b0;
    logic n_poll_en = 1'b0;

    logic s_pad_data, s_pad_latch, s_pad_clock, s_frame_valid, s_frame_err, s_busy;
    logic [S_BITS-1:0] s_buttons;
    logic n_pad_data, n_pad_latch, n_pad_clock, n_frame_valid, n_frame_err, n_busy;
    logic [N_BITS-1:0] n_buttons;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pad_serial_reader #(.NUM_BITS(S_BITS), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF),
                        .POLL_CYCLES(S_POLL)) u_snes (
        .clk(clk), .reset(reset), .poll_en(s_poll_en), .pad_data(s_pad_data),
        .pad_latch(s_pad_latch), .pad_clock(s_pad_clock), .buttons(s_buttons),
        .frame_valid(s_frame_valid), .frame_err(s_frame_err), .busy(s_busy));

    pad_serial_reader #(.NUM_BITS(N_BITS), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF),
                        .POLL_CYCLES(N_POLL)) u_nes (
        .clk(clk), .reset(reset), .poll_en(n_poll_en), .pad_data(n_pad_data),
        .pad_latch(n_pad_latch), .pad_clock(n_pad_clock), .buttons(n_buttons),
        .frame_valid(n_frame_valid), .frame_err(n_frame_err), .busy(n_busy));

    // Controller models: pattern bit k = 1 means button k pressed (line driven 0).
    logic [S_BITS-1:0] s_pat = '0;
    logic [N_BITS-1:0] n_pat = '0;
    int s_pidx = 0;
    int n_pidx = 0;

    always @(posedge s_pad_latch or posedge s_pad_clock) begin
        if (s_pad_latch) s_pidx <= 0;
        else             s_pidx <= s_pidx + 1;
    end
    always @(posedge n_pad_latch or posedge n_pad_clock) begin
        if (n_pad_latch) n_pidx <= 0;
        else             n_pidx <= n_pidx + 1;
    end
    assign s_pad_data = (s_pidx < S_BITS) ? ~s_pat[s_pidx[3:0]] : 1'b1;
    assign n_pad_data = (n_pidx < N_BITS) ? ~n_pat[n_pidx[2:0]] : 1'b1;

    // Observers: frame starts, frame_valid cycles, latch width, clock pulses.
    int s_starts[$];
    int s_valids[$];
    int n_starts[$];
    int n_valids[$];
    int s_latch_cnt = 0, s_latch_len = 0, s_falls = 0, s_pulses = 0, s_errs = 0;
    int n_latch_cnt = 0, n_latch_len = 0, n_falls = 0, n_pulses = 0, n_errs = 0;
    logic s_latch_q = 1'b0, s_clock_q = 1'b1;
    logic n_latch_q = 1'b0, n_clock_q = 1'b1;

    always @(negedge clk) begin
        s_latch_q <= s_pad_latch;
        s_clock_q <= s_pad_clock;
        if (s_pad_latch) s_latch_cnt <= s_latch_cnt + 1;
        else if (s_latch_q) begin s_latch_len <= s_latch_cnt; s_latch_cnt <= 0; end
        if (s_pad_latch && !s_latch_q) begin s_starts.push_back(cyc); s_falls <= 0; end
        else if (!s_pad_clock && s_clock_q) s_falls <= s_falls + 1;
        if (s_frame_valid) begin s_valids.push_back(cyc); s_pulses <= s_falls; end
        if (s_frame_err) s_errs <= s_errs + 1;
    end

    always @(negedge clk) begin
        n_latch_q <= n_pad_latch;
        n_clock_q <= n_pad_clock;
        if (n_pad_latch) n_latch_cnt <= n_latch_cnt + 1;
        else if (n_latch_q) begin n_latch_len <= n_latch_cnt; n_latch_cnt <= 0; end
        if (n_pad_latch && !n_latch_q) begin n_starts.push_back(cyc); n_falls <= 0; end
        else if (!n_pad_clock && n_clock_q) n_falls <= n_falls + 1;
        if (n_frame_valid) begin n_valids.push_back(cyc); n_pulses <= n_falls; end
        if (n_frame_err) n_errs <= n_errs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ev_count(input int sel);
        case (sel)
            0:       return s_starts.size();
            1:       return s_valids.size();
            2:       return n_starts.size();
            default: return n_valids.size();
        endcase
    endfunction

    // Wait (bounded) until the selected event queue holds target entries.
    task automatic wait_ev(input int sel, input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (ev_count(sel) < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 32'(ev_count(sel) >= target), 32'd1);
    endtask

    logic [S_BITS-1:0] s_exp;
    logic [N_BITS-1:0] n_exp;
    int n;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_latch",  32'(s_pad_latch), 32'd0);
        check("rst_clock",  32'(s_pad_clock), 32'd1);
        check("rst_buttons", 32'(s_buttons), 32'd0);
        check("rst_valid",  32'(s_frame_valid), 32'd0);
        check("rst_err",    32'(s_frame_err), 32'd0);
        check("rst_busy",   32'(s_busy), 32'd0);
        check("rst_nes_clock", 32'(n_pad_clock), 32'd1);
        check("rst_nes_buttons", 32'(n_buttons), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("no_poll_no_frame", 32'(s_starts.size()), 32'd0);

        // Three polled SNES frames; poll_en drops in the middle of the third.
        for (int f = 0; f < 3; f++) begin
            if (f == 0)      s_pat = 16'($urandom) & 16'h0FFF;
            else if (f == 1) s_pat = 16'h0000;
            else             s_pat = (16'($urandom) & 16'h0FFF) | 16'h0001;
            s_exp = s_pat;
            if (f == 0) s_poll_en = 1'b1;
            if (f == 2) begin
                wait_ev(0, 3, S_POLL + 20, "frame3_start");
                repeat (40) @(negedge clk);
                #1;
                check("busy_mid_frame", 32'(s_busy), 32'd1);
                s_poll_en = 1'b0;
            end
            wait_ev(1, f + 1, S_POLL + 20, "frame_valid_seen");
            check("buttons", 32'(s_buttons), 32'(s_exp));
            check("start_to_valid", 32'(s_valids[$] - s_starts[$]), 32'(S_FRAME));
            check("clock_pulses", 32'(s_pulses), 32'(S_BITS));
            check("latch_width", 32'(s_latch_len), 32'(LAT));
            check("busy_after_done", 32'(s_busy), 32'd0);
        end
        check("poll_spacing_1", 32'(s_starts[1] - s_starts[0]), 32'(S_POLL));
        check("poll_spacing_2", 32'(s_starts[2] - s_starts[1]), 32'(S_POLL));
        repeat (450) @(negedge clk);
        #1;
        check("no_4th_latch", 32'(s_starts.size()), 32'd3);
        check("buttons_hold", 32'(s_buttons), 32'(s_exp));

        // Reset during the LOW phase of bit 5.
        s_poll_en = 1'b1;
        wait_ev(0, 4, S_POLL + 20, "frame4_start");
        n = 0;
        while (s_falls < 6 && n < 200) begin @(negedge clk); #1; n++; end
        check("reached_bit5_low", 32'(s_pad_clock), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_clock",   32'(s_pad_clock), 32'd1);
        check("midrst_latch",   32'(s_pad_latch), 32'd0);
        check("midrst_busy",    32'(s_busy), 32'd0);
        check("midrst_buttons", 32'(s_buttons), 32'd0);
        s_pat = 16'($urandom) & 16'h0FFF;
        s_exp = s_pat;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_ev(1, 4, S_FRAME + 20, "post_reset_valid");
        s_poll_en = 1'b0;
        check("post_reset_buttons", 32'(s_buttons), 32'(s_exp));
        check("post_reset_timing", 32'(s_valids[$] - s_starts[$]), 32'(S_FRAME));
        check("post_reset_pulses", 32'(s_pulses), 32'(S_BITS));

        // Bit 13 pressed: rejected with the frame check, accepted without it.
        s_pat = (16'($urandom) & 16'h0FFF) | 16'h2000;
        s_poll_en = 1'b1;
        wait_ev(0, 6, S_POLL + 20, "bit13_start");
        s_poll_en = 1'b0;
        repeat (S_FRAME + 4) @(negedge clk);
        #1;
`ifdef PAD_FRAME_CHECK_EN
        check("bit13_err", 32'(s_errs), 32'd1);
        check("bit13_no_valid", 32'(s_valids.size()), 32'd4);
        check("bit13_buttons_kept", 32'(s_buttons), 32'(s_exp));
`else
        s_exp = s_pat;
        check("bit13_valid", 32'(s_valids.size()), 32'd5);
        check("bit13_buttons", 32'(s_buttons), 32'(s_exp));
        check("bit13_set", 32'(s_buttons[13]), 32'd1);
        check("err_never", 32'(s_errs), 32'd0);
`endif

        // NES with a poll period shorter than a frame: back-to-back frames.
        n_pat = 8'h81;
        n_exp = n_pat;
        n_poll_en = 1'b1;
        wait_ev(3, 1, N_FRAME + 20, "nes_valid1");
        check("nes_buttons1", 32'(n_buttons), 32'(n_exp));
        check("nes_timing1", 32'(n_valids[0] - n_starts[0]), 32'(N_FRAME));
        check("nes_pulses1", 32'(n_pulses), 32'(N_BITS));
        check("nes_latch_width", 32'(n_latch_len), 32'(LAT));
        n_pat = 8'($urandom);
        n_exp = n_pat;
        wait_ev(3, 2, N_FRAME + 20, "nes_valid2");
        n_poll_en = 1'b0;
        check("nes_back_to_back", 32'(n_starts[1]), 32'(n_valids[0]));
        check("nes_buttons2", 32'(n_buttons), 32'(n_exp));
        check("nes_timing2", 32'(n_valids[1] - n_starts[1]), 32'(N_FRAME));
        check("nes_err_never", 32'(n_errs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
